// File: rtl/fixed_softmax_max_subtract.sv
// Numerically-stable softmax front end: buffers one vector, tracks its signed
// maximum while it streams in, then replays every element as sat(x - max) <= 0.
module fixed_softmax_max_subtract #(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 4,
    parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int unsigned IN_0_DEPTH =
        DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0,
    parameter int unsigned DATA_OUT_0_PRECISION_0      = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int PAR    = int'(DATA_IN_0_PARALLELISM_DIM_0);
    localparam int DEPTH  = int'(IN_0_DEPTH);
    localparam int IN_W   = int'(DATA_IN_0_PRECISION_0);
    localparam int OUT_W  = int'(DATA_OUT_0_PRECISION_0);
    localparam int DIFF_W = IN_W + 1;
    // One spare bit above the wider of diff/output so the saturation compare is exact.
    localparam int EXT_W  = ((DIFF_W > OUT_W) ? DIFF_W : OUT_W) + 1;
    localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEVELS = (PAR > 1) ? $clog2(PAR) : 0;
    localparam int LEAVES = 1 << LEVELS;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);
    // -2^(OUT_W-1) at EXT_W bits.
    localparam logic [EXT_W-1:0] SAT_MIN   = ~((EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1));

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic signed [IN_W-1:0]  max_q, max_d;
    logic                    ready_en_q;
    logic signed [IN_W-1:0]  lane_max;
    logic                    in_fire;
    logic                    out_fire;
    logic [IN_W-1:0]         buffer [DEPTH][PAR];

    assign data_in_0_ready  = (state_q == StFill) && ready_en_q;
    assign data_out_0_valid = (state_q == StDrain);
    assign in_fire          = data_in_0_valid && data_in_0_ready;
    assign out_fire         = data_out_0_valid && data_out_0_ready;

    // Signed comparator tree over the lanes of the incoming beat; unused leaves
    // repeat lane 0 so they never change the result.
    always_comb begin : lane_max_tree
        logic signed [IN_W-1:0] node [2*LEAVES];
        for (int i = 0; i < 2 * LEAVES; i++) begin
            node[i] = $signed(data_in_0[0]);
        end
        for (int i = 0; i < PAR; i++) begin
            node[LEAVES+i] = $signed(data_in_0[i]);
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
        end
        lane_max = node[1];
    end

    // Next-state logic: fill counter and running max, then drain counter.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        max_d    = max_q;
        unique case (state_q)
            StFill: begin
                if (in_fire) begin
                    // First beat loads directly so no max carries over between vectors.
                    if ((wr_cnt_q == '0) || (lane_max > max_q)) begin
                        max_d = lane_max;
                    end
                    if (wr_cnt_q == LAST_BEAT) begin
                        wr_cnt_d = '0;
                        state_d  = StDrain;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_fire) begin
                    if (rd_cnt_q == LAST_BEAT) begin
                        rd_cnt_d = '0;
                        state_d  = StFill;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Control state; reset discards any vector in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFill;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            max_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            max_q      <= max_d;
            ready_en_q <= 1'b1;
        end
    end

    // Vector buffer; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < PAR; i++) begin
                buffer[wr_cnt_q][i] <= data_in_0[i];
            end
        end
    end

    // Output lanes: widened difference, saturate below the output minimum, else truncate.
    always_comb begin : sub_sat
        logic [DIFF_W-1:0] diff;
        logic [EXT_W-1:0]  diff_ext;
        for (int i = 0; i < PAR; i++) begin
            diff     = {buffer[rd_cnt_q][i][IN_W-1], buffer[rd_cnt_q][i]}
                     - {max_q[IN_W-1], max_q};
            diff_ext = {{(EXT_W - DIFF_W){diff[DIFF_W-1]}}, diff};
            if ($signed(diff_ext) < $signed(SAT_MIN)) begin
                data_out_0[i] = SAT_MIN[OUT_W-1:0];
            end else begin
                data_out_0[i] = diff_ext[OUT_W-1:0];
            end
        end
    end

endmodule
